stopwatch_ctrl: RTL and testbench

//  Control sequencer for the stopwatch counter/display datapath.
//  - Conditions the raw start/stop/clear buttons: synchronise, debounce, rising edge.
//  - Runs the RUN/PAUSED/IDLE state machine.
//  - Generates the 0.1 s count-enable tick and the counter clear pulse that drive the digit counters.
//  - Sits between the board button pins and the counter/seven-segment datapath, inside top.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_ctrl_btn_conditioner.sv | 52 +++++
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } sw_state_t;

  // Prescaler divide ratio between the system clock and the count tick.
  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// Button conditioner: 2-flop synchroniser, debounce counter, registered
// rising-edge press pulse on the debounced level.
module btn_conditioner #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_q;
  logic          r_press;

  // Synchronise, count consecutive disagreeing cycles, flip level, detect rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions the start/stop/clear buttons,
// runs the IDLE/RUN/PAUSED machine and generates count_en / count_clr.
// Optional lap (display hold) feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic clear_btn,
  output logic count_en,
  output logic count_clr,
  output logic running,
  output logic paused,
  output logic disp_hold
);

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          w_start_press;
  logic          w_stop_press;
  logic          w_clear_press;
  // Debounced levels are not needed by the sequencer itself.
  logic [2:0]    w_unused_levels;

  sw_state_t     r_state;
  logic [PW-1:0] r_presc;
  logic          r_count_en;
  logic          r_count_clr;
  logic          r_running;
  logic          r_paused;
`ifdef STOPWATCH_LAP_EN
  logic          r_hold;
`endif

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk(clk), .reset(reset), .raw(start_btn),
    .level(w_unused_levels[0]), .press(w_start_press)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_stop (
    .clk(clk), .reset(reset), .raw(stop_btn),
    .level(w_unused_levels[1]), .press(w_stop_press)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clk(clk), .reset(reset), .raw(clear_btn),
    .level(w_unused_levels[2]), .press(w_clear_press)
  );

  // State machine, prescaler and registered outputs; clear > stop > start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_count_en  <= 1'b0;
      r_count_clr <= 1'b0;
      r_running   <= 1'b0;
      r_paused    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_hold      <= 1'b0;
`endif
    end else begin
      r_count_en  <= 1'b0;
      r_count_clr <= 1'b0;

      // Prescaler counts cycles spent in RUN, holds in PAUSED, zero in IDLE.
      if (w_clear_press || (r_state == ST_IDLE)) begin
        r_presc <= '0;
      end else if (r_state == ST_RUN) begin
        if (r_presc == PW'(TICK_DIV - 1)) begin
          r_presc    <= '0;
          r_count_en <= 1'b1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end

      if (w_clear_press) begin
        r_state     <= ST_IDLE;
        r_count_clr <= 1'b1;
        r_running   <= 1'b0;
        r_paused    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
        r_hold      <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_press && !w_stop_press) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_stop_press) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
              r_paused  <= 1'b1;
`ifdef STOPWATCH_LAP_EN
              r_hold    <= 1'b0;
            end else if (w_start_press) begin
              r_hold    <= ~r_hold;
`endif
            end
          end
          ST_PAUSED: begin
            if (w_start_press && !w_stop_press) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_paused  <= 1'b0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_paused  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_en  = r_count_en;
  assign count_clr = r_count_clr;
  assign running   = r_running;
  assign paused    = r_paused;
`ifdef STOPWATCH_LAP_EN
  assign disp_hold = r_hold;
`else
  assign disp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a small clock (TICK_DIV=10, DB_CYCLES=4).
// Reference model: a button level flips once the last DB_CYCLES samples
// seen through the 2-cycle synchroniser all disagree with it; the press is
// seen two edges after that, the state one edge later. Count ticks are
// derived from the number of cycles spent in RUN modulo TICK_DIV.
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_HZ  = 100;
  localparam int unsigned TICK_HZ = 10;
  localparam int unsigned TD      = CLK_HZ / TICK_HZ;
  localparam int unsigned DB      = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP = 1'b1;
`else
  localparam logic LAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_btn = 1'b0;
  logic stop_btn = 1'b0;
  logic clear_btn = 1'b0;
  logic count_en, count_clr, running, paused, disp_hold;
  logic [4:0] dut_vec;

  int n_err = 0;
  int n_chk = 0;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .count_en(count_en), .count_clr(count_clr),
    .running(running), .paused(paused), .disp_hold(disp_hold)
  );

  always #5 clk = ~clk;

  assign dut_vec = {count_en, count_clr, running, paused, disp_hold};

  // ---------------- reference model ----------------
  logic [7:0] m_hist [3];
  logic       m_lvl  [3];
  logic       m_rise [3];
  logic       m_press[3];
  int         m_state;
  int         m_run;
  logic       m_cen, m_clr, m_hold;

  always @(posedge clk) begin
    logic [2:0] raw;
    logic ps, pt, pc, all_diff;
    raw = {clear_btn, stop_btn, start_btn};
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = '0; m_lvl[b] = 1'b0; m_rise[b] = 1'b0; m_press[b] = 1'b0;
      end
      m_state = M_IDLE; m_run = 0; m_cen = 1'b0; m_clr = 1'b0; m_hold = 1'b0;
    end else begin
      ps = m_press[0]; pt = m_press[1]; pc = m_press[2];
      for (int b = 0; b < 3; b++) begin
        m_press[b] = m_rise[b];
        m_rise[b]  = 1'b0;
        all_diff   = 1'b1;
        for (int j = 1; j <= int'(DB); j++)
          if (m_hist[b][j] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[b]  = ~m_lvl[b];
          m_rise[b] = m_lvl[b];
        end
        m_hist[b] = {m_hist[b][6:0], raw[b]};
      end
      m_cen = 1'b0;
      m_clr = 1'b0;
      if (pc) begin
        m_clr = 1'b1; m_state = M_IDLE; m_run = 0; m_hold = 1'b0;
      end else begin
        if (m_state == M_RUN) begin
          m_run = m_run + 1;
          if (m_run % int'(TD) == 0) m_cen = 1'b1;
        end
        if (pt) begin
          if (m_state == M_RUN) begin m_state = M_PAUSE; m_hold = 1'b0; end
        end else if (ps) begin
          if (m_state != M_RUN) m_state = M_RUN;
          else if (LAP) m_hold = ~m_hold;
        end
      end
    end
  end

  function automatic logic [4:0] exp_vec();
    return {m_cen, m_clr, (m_state == M_RUN), (m_state == M_PAUSE), m_hold};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 1; k <= 6; k++) begin
      reset = (k <= 3); start_btn = 0; stop_btn = 0; clear_btn = 0;
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL reset_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      n_chk++;
      if (dut_vec !== 5'b0) begin
        n_err++; $display("FAIL reset_zero k=%0d got=%b exp=00000", k, dut_vec);
      end
    end
  endtask

  task automatic test_start_hold();
    int first_run = -1, first_cen = -1, n_cen = 0, n_hold = 0;
    for (int k = 1; k <= 25; k++) begin
      start_btn = (k <= 20);
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL start_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (running && first_run < 0) first_run = k;
      if (count_en) begin n_cen++; if (first_cen < 0) first_cen = k; end
      if (disp_hold) n_hold++;
    end
    n_chk++;
    if (first_run !== 8) begin n_err++; $display("FAIL start_run_edge got=%0d exp=8", first_run); end
    n_chk++;
    if (first_cen !== 18 || n_cen !== 1) begin
      n_err++; $display("FAIL start_first_tick got=%0d/%0d exp=18/1", first_cen, n_cen);
    end
    n_chk++;
    if (n_hold !== 0) begin n_err++; $display("FAIL start_single_press got=%0d exp=0", n_hold); end
  endtask

  task automatic test_pause();
    int first_pause = -1, cen_paused = 0, rerun = -1, next_cen = -1;
    for (int k = 1; k <= 75; k++) begin
      stop_btn  = (k <= 6);
      start_btn = (k >= 59 && k <= 64);
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL pause_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (paused && first_pause < 0) first_pause = k;
      if (k >= 9 && k <= 58 && count_en) cen_paused++;
      if (k >= 59 && running && rerun < 0) rerun = k;
      if (k >= 59 && count_en && next_cen < 0) next_cen = k;
    end
    n_chk++;
    if (first_pause !== 8) begin n_err++; $display("FAIL pause_edge got=%0d exp=8", first_pause); end
    n_chk++;
    if (cen_paused !== 0) begin n_err++; $display("FAIL pause_silent got=%0d exp=0", cen_paused); end
    n_chk++;
    if (rerun !== 66 || next_cen !== 71) begin
      n_err++; $display("FAIL pause_resume_tick got=%0d/%0d exp=66/71", rerun, next_cen);
    end
  endtask

  task automatic test_clear();
    int n_clr = 0, clr_k = -1, run_at_clr = 1, first_run = -1, first_cen = -1;
    for (int k = 1; k <= 45; k++) begin
      clear_btn = (k <= 5);
      start_btn = (k >= 21 && k <= 25);
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL clear_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (count_clr) begin n_clr++; clr_k = k; end
      if (k == 8) run_at_clr = running | paused;
      if (k >= 21 && running && first_run < 0) first_run = k;
      if (k >= 21 && count_en && first_cen < 0) first_cen = k;
    end
    n_chk++;
    if (n_clr !== 1 || clr_k !== 8) begin
      n_err++; $display("FAIL clear_pulse got=%0d@%0d exp=1@8", n_clr, clr_k);
    end
    n_chk++;
    if (run_at_clr !== 1'b0) begin n_err++; $display("FAIL clear_state got=%b exp=0", run_at_clr); end
    n_chk++;
    if (first_run !== 28 || first_cen !== 38) begin
      n_err++; $display("FAIL clear_restart got=%0d/%0d exp=28/38", first_run, first_cen);
    end
  endtask

  task automatic test_glitch();
    int n_act = 0;
    for (int k = 1; k <= 45; k++) begin
      clear_btn = (k <= 5);
      start_btn = (k >= 12 && k <= 14) || (k >= 22 && k <= 33 && k[0]);
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL glitch_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (k >= 8 && (running || paused)) n_act++;
    end
    n_chk++;
    if (n_act !== 0) begin n_err++; $display("FAIL glitch_idle got=%0d exp=0", n_act); end
  endtask

  task automatic test_simultaneous();
    int run_in_pause = 0, paused_35 = 0, clr_59 = 0, run_59 = 1, late_run = 0;
    for (int k = 1; k <= 85; k++) begin
      start_btn = (k <= 5) || (k >= 24 && k <= 28) || (k >= 40 && k <= 44)
                  || (k >= 52 && k <= 56) || (k >= 64 && k <= 67);
      stop_btn  = (k >= 12 && k <= 16) || (k >= 24 && k <= 28);
      clear_btn = (k >= 52 && k <= 56);
      reset     = (k == 68);
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL simul_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (k >= 20 && k <= 40 && running) run_in_pause++;
      if (k == 35) paused_35 = paused;
      if (k == 59) begin clr_59 = count_clr; run_59 = running | paused; end
      if (k >= 68 && (running || paused)) late_run++;
    end
    reset = 1'b0;
    n_chk++;
    if (run_in_pause !== 0 || paused_35 !== 1) begin
      n_err++; $display("FAIL simul_start_stop got=%0d/%0d exp=0/1", run_in_pause, paused_35);
    end
    n_chk++;
    if (clr_59 !== 1 || run_59 !== 0) begin
      n_err++; $display("FAIL simul_clear_start got=%0d/%0d exp=1/0", clr_59, run_59);
    end
    n_chk++;
    if (late_run !== 0) begin n_err++; $display("FAIL simul_reset_debounce got=%0d exp=0", late_run); end
  endtask

  task automatic test_lap();
    logic h20 = 0, h32 = 0, h44 = 0, h56 = 1, p56 = 0, r44 = 0;
    int n_cen = 0;
    for (int k = 1; k <= 60; k++) begin
      start_btn = (k <= 5) || (k >= 12 && k <= 16) || (k >= 24 && k <= 28)
                  || (k >= 36 && k <= 40);
      stop_btn  = (k >= 48 && k <= 52);
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL lap_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (k >= 9 && k <= 55 && count_en) n_cen++;
      if (k == 20) h20 = disp_hold;
      if (k == 32) h32 = disp_hold;
      if (k == 44) begin h44 = disp_hold; r44 = running; end
      if (k == 56) begin h56 = disp_hold; p56 = paused; end
    end
    n_chk++;
    if (h20 !== LAP || h32 !== 1'b0 || h44 !== LAP) begin
      n_err++; $display("FAIL lap_toggle got=%b%b%b exp=%b0%b", h20, h32, h44, LAP, LAP);
    end
    n_chk++;
    if (h56 !== 1'b0 || p56 !== 1'b1 || r44 !== 1'b1) begin
      n_err++; $display("FAIL lap_stop_clears got=%b/%b/%b exp=0/1/1", h56, p56, r44);
    end
    n_chk++;
    if (n_cen !== 4) begin n_err++; $display("FAIL lap_ticks got=%0d exp=4", n_cen); end
  endtask

  task automatic test_random();
    int hold_left[3] = '{0, 0, 0};
    logic lvl[3] = '{0, 0, 0};
    for (int k = 1; k <= 800; k++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold_left[b] == 0) begin
          lvl[b]       = (b == 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
          hold_left[b] = $urandom_range(1, 14);
        end
        hold_left[b]--;
      end
      start_btn = lvl[0]; stop_btn = lvl[1]; clear_btn = lvl[2];
      reset     = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    reset = 1'b0; start_btn = 0; stop_btn = 0; clear_btn = 0;
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_pause();
    test_clear();
    test_glitch();
    test_simultaneous();
    test_lap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
